dmem_wait_responder: RTL and testbench
======================================

Name: dmem_wait_responder

Overview:
- Data-memory responder for the pipelined ARM datapath's Memory stage.
- Accepts word read/write requests driven from the M-stage pipeline registers (address, write data, MemRead/MemWrite).
- Returns read data and drives Ready, which the core uses as its pipeline Enable.
- Inserts a configurable number of wait states, stalling the whole pipeline until each access completes.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array; index = A[ADDR_W+1:2], where ADDR_W = $clog2(DEPTH_WORDS).
- WAIT_CYCLES, 2, stall cycles per access; legal range 1..15.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRead  in  1  M-stage read request.
- MemWrite  in  1  M-stage write request.
- A  in  32  byte address (ALUOutM).
- WD  in  32  write data (WriteDataM).
- RD  out  32  read data (ReadDataM); registered.
- Ready  out  1  pipeline enable; 1 = pipeline may advance this edge.
- Error  out  1  one-cycle pulse: the completing access was misaligned or out of range.

Behaviour:
- Reset values: while reset=0, asynchronously:
  - state=IDLE, cnt=0, RD=0, Error=0.
  - Ready=1.
  - Array contents are not reset.
- req = MemRead | MemWrite.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Ready = ~req, combinational from req.
  - On req: cnt <= 1. Go to DONE if WAIT_CYCLES==1, else go to WAIT.
- WAIT:
  - Ready=0; cnt increments each cycle.
  - When cnt==WAIT_CYCLES-1: go to DONE.
- Read-data capture:
  - On the edge entering DONE, RD <= mem[index] (pre-write value) if the access is a legal read; RD <= 0 if the access is illegal.
  - On a write-only access RD holds its previous value.
- DONE:
  - Ready=1.
  - At the closing edge, if MemWrite and the access is legal: mem[index] <= WD.
  - Next state is always IDLE, even if req is still high; the request now present belongs to the next M-stage instruction.
- Latency:
  - Exactly WAIT_CYCLES cycles with Ready=0, then one DONE cycle.
  - Back-to-back accesses therefore cost WAIT_CYCLES+1 cycles each.
- A, WD, MemRead and MemWrite are held stable by the stalled pipeline. The responder samples them every cycle and does not latch them.
- MemRead and MemWrite both high: treated as a write. RD returns the pre-write word.
- Illegal access: A[1:0]!=0, or index >= DEPTH_WORDS (A[31:ADDR_W+2] nonzero).
  - The write is suppressed and RD=0.
  - Error=1 during the DONE cycle only.
- Reset mid-access (WAIT or DONE): the FSM returns to IDLE immediately, the pending write is dropped, and RD is cleared.
- cnt is 4 bits wide. It saturates and never wraps, because the WAIT exit comparison guarantees termination.

Optional Feature:
- Macro: DMEM_BYTEWRITE_EN.
- Defined:
  - Adds input port ByteEn[3:0].
  - In DONE, only lanes with ByteEn[i]=1 are written: mem[index][8i+7:8i] <= WD[8i+7:8i].
  - ByteEn=0000 with MemWrite is a legal no-op write.
  - Reads are unaffected.
- Undefined: no ByteEn port; every write updates the full word.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, DONE} dmem_state_t;
  - localparam WORD_BYTES=4;
  - localparam CNT_W=4.
- Sub-module wait_counter: loadable saturating counter (clk, reset, load, inc, cnt, hit). It asserts hit when cnt==WAIT_CYCLES-1 and is instantiated once.
- The FSM and the array stay in dmem_wait_responder.

Test Plan:
- Reset then idle: with reset=0, RD=0, Ready=1, Error=0. Release reset with no req: Ready stays 1 and state stays IDLE.
- Write then read, WAIT_CYCLES=2:
  - MemWrite, A=0x10, WD=0xDEADBEEF: Ready=0 for 2 cycles, then DONE with Ready=1.
  - Next MemRead A=0x10: after 2 stall cycles, RD=0xDEADBEEF in DONE.
- Back-to-back requests: req held high across two instructions. Ready pattern is 0,0,1,0,0,1 with no third access started.
- Illegal accesses:
  - MemWrite, A=0x13: Error=1 in DONE only; a subsequent read of 0x10 still returns the old value.
  - MemRead, A=0x100 (DEPTH_WORDS=64): Error=1 and RD=0.
- Reset mid-access: MemWrite A=0x20, WD=0x12345678; assert reset in WAIT. Ready returns to 1 and a later read of 0x20 does not return 0x12345678.
- Byte lanes (DMEM_BYTEWRITE_EN): write 0xAABBCCDD, then write WD=0x11223344 with ByteEn=0101 to the same word. A read returns 0xAA22CC44.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} dmem_state_t;
    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;
endpackage

// File: rtl/dmem_wait_responder_wait_counter.sv
// Loadable saturating stall counter; hit marks the last wait-state cycle.
module wait_counter
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);
    logic [CNT_W-1:0] r_cnt;

    // Load to 1 on a new access, then count up and stick at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (load) begin
            r_cnt <= CNT_W'(1);
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;
    assign hit = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
endmodule

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with WAIT_CYCLES stall cycles per access for the M stage.
// Optional per-byte write lanes via the DMEM_BYTEWRITE_EN macro (adds ByteEn).
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] A,
    input  logic [31:0] WD,
`ifdef DMEM_BYTEWRITE_EN
    input  logic [3:0]  ByteEn,
`endif
    output logic [31:0] RD,
    output logic        Ready,
    output logic        Error
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    localparam int OFF_W  = $clog2(WORD_BYTES);

    dmem_state_t      r_state;
    dmem_state_t      w_next;
    logic [31:0]      r_rd;
    logic             r_error;
    logic [31:0]      r_mem [DEPTH_WORDS];
    logic [CNT_W-1:0] w_cnt;
    logic             w_hit;
    logic             w_load;
    logic             w_inc;
    logic             w_ready;
    logic             w_enter_done;
    logic             w_req;
    logic             w_legal;
    logic             w_do_write;
    logic [ADDR_W-1:0] w_index;

    assign w_req      = MemRead | MemWrite;
    assign w_index    = A[ADDR_W+OFF_W-1:OFF_W];
    assign w_legal    = (A[OFF_W-1:0] == {OFF_W{1'b0}})
                      && ((A >> (ADDR_W + OFF_W)) == 32'd0)
                      && (32'(w_index) < 32'(DEPTH_WORDS));
    assign w_do_write = (r_state == DONE) && MemWrite && w_legal;

    wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .inc   (w_inc),
        .cnt   (w_cnt),
        .hit   (w_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, counter control and ready generation.
    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_ready      = 1'b1;
        w_enter_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~w_req;
                if (w_req) begin
                    w_load = 1'b1;
                    if (WAIT_CYCLES == 32'sd1) begin
                        w_next       = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                w_ready = 1'b0;
                w_inc   = 1'b1;
                // Saturation exit keeps the FSM live even for an out-of-range WAIT_CYCLES.
                if (w_hit || (w_cnt == {CNT_W{1'b1}})) begin
                    w_next       = DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
        endcase
    end

    // Read data and error are captured on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd    <= 32'd0;
            r_error <= 1'b0;
        end else begin
            r_error <= w_enter_done & ~w_legal;
            if (w_enter_done) begin
                if (!w_legal) begin
                    r_rd <= 32'd0;
                end else if (MemRead) begin
                    r_rd <= r_mem[w_index];
                end
            end
        end
    end

    // Array write at the closing edge of DONE; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
`ifdef DMEM_BYTEWRITE_EN
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (ByteEn[i]) begin
                    r_mem[w_index][8*i +: 8] <= WD[8*i +: 8];
                end
            end
`else
            r_mem[w_index] <= WD;
`endif
        end
    end

    assign RD    = r_rd;
    assign Error = r_error;
    assign Ready = ~reset | w_ready;
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench: directed table, hand sequences, and random accesses vs a word-array model.
module tb_dmem_wait_responder;
    localparam int DEPTH = 64;
    localparam int WC    = 2;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] A;
    logic [31:0] WD;
`ifdef DMEM_BYTEWRITE_EN
    logic [3:0]  ByteEn;
`endif
    logic [31:0] RD;
    logic        Ready;
    logic        Error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rd;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t tbl [15];

    dmem_wait_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .A        (A),
        .WD       (WD),
`ifdef DMEM_BYTEWRITE_EN
        .ByteEn   (ByteEn),
`endif
        .RD       (RD),
        .Ready    (Ready),
        .Error    (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < 32'(4 * DEPTH));
    endfunction

    // One access: WC stall cycles with Ready=0, then DONE with Ready=1; model updated afterwards.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic [31:0] exp_rd, input bit exp_err);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; A = addr; WD = wd;
`ifdef DMEM_BYTEWRITE_EN
        ByteEn = be;
`endif
        for (int k = 0; k < WC; k++) begin
            @(negedge clk);
            check("ready_stall", {31'd0, Ready}, 32'd0);
            check("error_stall", {31'd0, Error}, 32'd0);
        end
        @(negedge clk);
        check("ready_done", {31'd0, Ready}, 32'd1);
        check("rd_done", RD, exp_rd);
        check("error_done", {31'd0, Error}, {31'd0, exp_err});
        last_rd = exp_rd;
        if (wr && is_legal(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_m[addr >> 2][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    task automatic go_idle(input int n);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("ready_idle", {31'd0, Ready}, 32'd1);
            check("error_idle", {31'd0, Error}, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] addr, wd, exp_rd;
        bit rd, wr, leg;
        int kind;
        bit [5:0] pat;

        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; A = 32'd0; WD = 32'd0;
`ifdef DMEM_BYTEWRITE_EN
        ByteEn = 4'hF;
`endif
        last_rd = 32'd0;
        #1;
        check("reset_rd", RD, 32'd0);
        check("reset_ready_with_req", {31'd0, Ready}, 32'd1);
        check("reset_error", {31'd0, Error}, 32'd0);
        MemRead = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_ready", {31'd0, Ready}, 32'd1);
            check("post_reset_rd", RD, 32'd0);
        end

        // rd, wr, addr, wd, expected RD, expected Error
        tbl[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h13,       32'h11111111, 32'h0,        1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h14,       32'h00000055, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h10,       32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hCAFEF00D, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'hFC,       32'h0BADF00D, 32'hCAFEF00D, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'hFC,       32'h0,        32'h0BADF00D, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h102,      32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 1'b1, 32'h80000000, 32'h99999999, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 1'b1, 32'h20,       32'h00C0FFEE, 32'h0,        1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h14,       32'h0,        32'h00000055, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 32'h20,       32'h0,        32'h00C0FFEE, 1'b0};
        for (int i = 0; i < 15; i++) begin
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, 4'hF, tbl[i].exp_rd, tbl[i].exp_err);
            if (i % 4 == 3) go_idle(1);
        end

        // Request held across two instructions: 0,0,1,0,0,1 then no third access.
        go_idle(1);
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; A = 32'h10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pat[k] = Ready;
        end
        check("b2b_ready_pattern", {26'd0, pat}, 32'b100100);
        check("b2b_rd", RD, 32'hCAFEF00D);
        go_idle(2);
        last_rd = 32'hCAFEF00D;

        // Reset asserted during WAIT drops the pending write and clears RD.
        @(posedge clk); #1;
        MemWrite = 1'b1; A = 32'h20; WD = 32'h12345678;
        @(negedge clk);
        check("mid_ready_stall", {31'd0, Ready}, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check("mid_reset_ready", {31'd0, Ready}, 32'd1);
        check("mid_reset_rd", RD, 32'd0);
        @(posedge clk); @(negedge clk);
        MemWrite = 1'b0; reset = 1'b1; last_rd = 32'd0;
        go_idle(2);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 32'h00C0FFEE, 1'b0);

`ifdef DMEM_BYTEWRITE_EN
        do_access(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, last_rd, 1'b0);
        do_access(1'b0, 1'b1, 32'h40, 32'h11223344, 4'b0101, last_rd, 1'b0);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hAA22CC44, 1'b0);
        do_access(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, last_rd, 1'b0);
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hAA22CC44, 1'b0);
`endif

        // Fill every word so random reads have a known model value.
        for (int i = 0; i < DEPTH; i++) begin
            do_access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, last_rd, 1'b0);
        end

        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(0, 2));
            rd = (kind != 1);
            wr = (kind != 0);
            case ($urandom_range(0, 9))
                7:       addr = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                8:       addr = 32'h100 + 32'($urandom_range(0, 255)) * 32'd4;
                9:       addr = {1'b1, 31'($urandom)};
                default: addr = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            endcase
            wd  = $urandom;
            leg = is_legal(addr);
            if (!leg)    exp_rd = 32'd0;
            else if (rd) exp_rd = mem_m[addr >> 2];
            else         exp_rd = last_rd;
            do_access(rd, wr, addr, wd, 4'hF, exp_rd, !leg);
            if ($urandom_range(0, 3) == 0) go_idle(int'($urandom_range(1, 2)));
        end

        go_idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
